// File: rtl/cfu_issue_pkg.sv
// Shared widths, id-width helper and CFU channel structs for the CFU issue unit.
package cfu_issue_pkg;

  localparam int DEPTH_DEF   = 4;
  localparam int TAG_W_DEF   = 6;
  localparam int FUNCT_W_DEF = 10;
  localparam int TIMEOUT_DEF = 256;

  function automatic int cfu_id_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  localparam int ID_W_DEF = cfu_id_width(DEPTH_DEF);

  typedef struct packed {
    logic [31:0]            data0;
    logic [31:0]            data1;
    logic [FUNCT_W_DEF-1:0] function_id;
    logic [ID_W_DEF-1:0]    id;
  } cfu_req_t;

  typedef struct packed {
    logic [31:0]         data;
    logic [ID_W_DEF-1:0] id;
  } cfu_resp_t;

endpackage

// File: rtl/cfu_issue_unit_tag_fifo.sv
// In-order tag FIFO; the read/write pointers double as CFU request ids.
module cfu_tag_fifo
  import cfu_issue_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int TAG_W = TAG_W_DEF,
  localparam int ID_W  = cfu_id_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] head_tag,
  output logic [ID_W-1:0]  wr_ptr,
  output logic [ID_W-1:0]  rd_ptr,
  output logic [ID_W:0]    count,
  output logic             full,
  output logic             empty
);

  logic [TAG_W-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (ID_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_tag = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  // DEPTH is a power of two, so plain increment wraps the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cfu_issue_unit.sv
// Core-side CFU initiator: registered request channel, in-order tag tracking, writeback.
// Optional watchdog abandons a stuck head request when CFU_ISSUE_TIMEOUT_EN is defined.
module cfu_issue_unit
  import cfu_issue_pkg::*;
#(
  parameter  int DEPTH          = DEPTH_DEF,
  parameter  int TAG_W          = TAG_W_DEF,
  parameter  int FUNCT_W        = FUNCT_W_DEF,
  parameter  int TIMEOUT_CYCLES = TIMEOUT_DEF,
  localparam int ID_W           = cfu_id_width(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [31:0]        issue_rs1,
  input  logic [31:0]        issue_rs2,
  input  logic [FUNCT_W-1:0] issue_funct,
  input  logic [TAG_W-1:0]   issue_tag,
  output logic               cfu_req_valid,
  input  logic               cfu_req_ready,
  output logic [31:0]        cfu_req_data0,
  output logic [31:0]        cfu_req_data1,
  output logic [FUNCT_W-1:0] cfu_req_function_id,
  output logic [ID_W-1:0]    cfu_req_id,
  input  logic               cfu_resp_valid,
  output logic               cfu_resp_ready,
  input  logic [31:0]        cfu_resp_data,
  input  logic [ID_W-1:0]    cfu_resp_id,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [31:0]        wb_data,
  output logic [TAG_W-1:0]   wb_tag,
  output logic               wb_err,
  output logic               err_unexpected
);

  logic             issue_fire;
  logic             resp_fire;
  logic             resp_pop;
  logic             wb_free;
  logic             timeout_fire;
  logic             fifo_pop;
  logic [TAG_W-1:0] head_tag;
  logic [ID_W-1:0]  wr_ptr;
  logic [ID_W-1:0]  rd_ptr;
  logic [ID_W:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  assign wb_free        = ~wb_valid | wb_ready;
  assign issue_ready    = (~cfu_req_valid | cfu_req_ready) & (fifo_count < (ID_W+1)'(DEPTH));
  assign issue_fire     = issue_valid & issue_ready;
  // Responses are always drained, even with nothing in flight, so a stray one cannot deadlock the CFU.
  assign cfu_resp_ready = wb_free;
  assign resp_fire      = cfu_resp_valid & cfu_resp_ready;
  assign resp_pop       = resp_fire & ~fifo_empty;
  assign fifo_pop       = resp_pop | timeout_fire;

  cfu_tag_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (issue_fire & ~fifo_full),
    .push_tag (issue_tag),
    .pop      (fifo_pop),
    .head_tag (head_tag),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef CFU_ISSUE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt;

  assign timeout_fire = (wd_cnt == WD_LIMIT) & ~fifo_empty & ~resp_fire & wb_free;

  // Saturates at the limit while the writeback register is still occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (resp_fire | fifo_empty | timeout_fire) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_LIMIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cfu_req_valid       <= 1'b0;
      cfu_req_data0       <= '0;
      cfu_req_data1       <= '0;
      cfu_req_function_id <= '0;
      cfu_req_id          <= '0;
    end else if (issue_fire) begin
      cfu_req_valid       <= 1'b1;
      cfu_req_data0       <= issue_rs1;
      cfu_req_data1       <= issue_rs2;
      cfu_req_function_id <= issue_funct;
      cfu_req_id          <= wr_ptr;
    end else if (cfu_req_ready) begin
      cfu_req_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid       <= 1'b0;
      wb_data        <= '0;
      wb_tag         <= '0;
      wb_err         <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      if (resp_pop) begin
        wb_valid <= 1'b1;
        wb_data  <= cfu_resp_data;
        wb_tag   <= head_tag;
        wb_err   <= (cfu_resp_id != rd_ptr);
      end else if (timeout_fire) begin
        wb_valid <= 1'b1;
        wb_data  <= '0;
        wb_tag   <= head_tag;
        wb_err   <= 1'b1;
      end else if (wb_ready) begin
        wb_valid <= 1'b0;
      end
      if (resp_fire & fifo_empty) err_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cfu_issue_unit.sv
// Directed self-checking bench for cfu_issue_unit.
module tb_cfu_issue_unit;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 6;
  localparam int FUNCT_W = 10;
  localparam int ID_W    = 2;

  logic               clk;
  logic               rst;
  logic               issue_valid;
  logic               issue_ready;
  logic [31:0]        issue_rs1;
  logic [31:0]        issue_rs2;
  logic [FUNCT_W-1:0] issue_funct;
  logic [TAG_W-1:0]   issue_tag;
  logic               cfu_req_valid;
  logic               cfu_req_ready;
  logic [31:0]        cfu_req_data0;
  logic [31:0]        cfu_req_data1;
  logic [FUNCT_W-1:0] cfu_req_function_id;
  logic [ID_W-1:0]    cfu_req_id;
  logic               cfu_resp_valid;
  logic               cfu_resp_ready;
  logic [31:0]        cfu_resp_data;
  logic [ID_W-1:0]    cfu_resp_id;
  logic               wb_valid;
  logic               wb_ready;
  logic [31:0]        wb_data;
  logic [TAG_W-1:0]   wb_tag;
  logic               wb_err;
  logic               err_unexpected;

  int n_pass  = 0;
  int n_total = 0;

  cfu_issue_unit #(
    .DEPTH          (DEPTH),
    .TAG_W          (TAG_W),
    .FUNCT_W        (FUNCT_W),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .issue_valid         (issue_valid),
    .issue_ready         (issue_ready),
    .issue_rs1           (issue_rs1),
    .issue_rs2           (issue_rs2),
    .issue_funct         (issue_funct),
    .issue_tag           (issue_tag),
    .cfu_req_valid       (cfu_req_valid),
    .cfu_req_ready       (cfu_req_ready),
    .cfu_req_data0       (cfu_req_data0),
    .cfu_req_data1       (cfu_req_data1),
    .cfu_req_function_id (cfu_req_function_id),
    .cfu_req_id          (cfu_req_id),
    .cfu_resp_valid      (cfu_resp_valid),
    .cfu_resp_ready      (cfu_resp_ready),
    .cfu_resp_data       (cfu_resp_data),
    .cfu_resp_id         (cfu_resp_id),
    .wb_valid            (wb_valid),
    .wb_ready            (wb_ready),
    .wb_data             (wb_data),
    .wb_tag              (wb_tag),
    .wb_err              (wb_err),
    .err_unexpected      (err_unexpected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "bench time limit reached");
  end

  // Inputs change on the falling edge; registered outputs are sampled there too.
  task automatic do_reset();
    rst            = 1'b1;
    issue_valid    = 1'b0;
    issue_rs1      = '0;
    issue_rs2      = '0;
    issue_funct    = '0;
    issue_tag      = '0;
    cfu_req_ready  = 1'b1;
    cfu_resp_valid = 1'b0;
    cfu_resp_data  = '0;
    cfu_resp_id    = '0;
    wb_ready       = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (cfu_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %0b want 0", cfu_req_valid); else n_pass++;
    n_total++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid: got %0b want 0", wb_valid); else n_pass++;
    n_total++; if (wb_err !== 1'b0) $display("FAIL reset_wb_err: got %0b want 0", wb_err); else n_pass++;
    n_total++; if (err_unexpected !== 1'b0) $display("FAIL reset_err_unexpected: got %0b want 0", err_unexpected); else n_pass++;
    n_total++; if ({cfu_req_data0, cfu_req_data1, wb_data} !== 96'h0) $display("FAIL reset_data: got %h %h %h want 0", cfu_req_data0, cfu_req_data1, wb_data); else n_pass++;
    n_total++; if ({issue_ready, cfu_resp_ready} !== 2'b11) $display("FAIL reset_readies: got %b want 11", {issue_ready, cfu_resp_ready}); else n_pass++;
  endtask

  task automatic test_single_op();
    do_reset();
    issue_valid = 1'b1; issue_rs1 = 32'h11; issue_rs2 = 32'h22; issue_funct = 10'd3; issue_tag = 6'd5;
    #1;
    n_total++; if (issue_ready !== 1'b1) $display("FAIL single_issue_ready: got %0b want 1", issue_ready); else n_pass++;
    @(negedge clk);
    issue_valid = 1'b0;
    n_total++; if (cfu_req_valid !== 1'b1) $display("FAIL single_req_valid: got %0b want 1", cfu_req_valid); else n_pass++;
    n_total++; if ({cfu_req_data0, cfu_req_data1} !== {32'h11, 32'h22}) $display("FAIL single_req_data: got %h %h want 11 22", cfu_req_data0, cfu_req_data1); else n_pass++;
    n_total++; if ({cfu_req_function_id, cfu_req_id} !== {10'd3, 2'd0}) $display("FAIL single_req_fid: got funct %0d id %0d want 3 0", cfu_req_function_id, cfu_req_id); else n_pass++;
    @(negedge clk);
    n_total++; if (cfu_req_valid !== 1'b0) $display("FAIL single_req_clear: got %0b want 0", cfu_req_valid); else n_pass++;
    cfu_resp_valid = 1'b1; cfu_resp_data = 32'hABCD; cfu_resp_id = 2'd0;
    @(negedge clk);
    cfu_resp_valid = 1'b0;
    n_total++; if (wb_valid !== 1'b1) $display("FAIL single_wb_valid: got %0b want 1", wb_valid); else n_pass++;
    n_total++; if (wb_data !== 32'hABCD) $display("FAIL single_wb_data: got %h want abcd", wb_data); else n_pass++;
    n_total++; if ({wb_tag, wb_err} !== {6'd5, 1'b0}) $display("FAIL single_wb_tag_err: got tag %0d err %0b want 5 0", wb_tag, wb_err); else n_pass++;
    @(negedge clk);
    n_total++; if (wb_valid !== 1'b0) $display("FAIL single_wb_clear: got %0b want 0", wb_valid); else n_pass++;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1; issue_tag = 6'(10 + i); issue_rs1 = 32'(i);
      #1;
      n_total++; if (issue_ready !== 1'b1) $display("FAIL fill_ready_%0d: got %0b want 1", i, issue_ready); else n_pass++;
      @(negedge clk);
      n_total++; if ({cfu_req_valid, cfu_req_id} !== {1'b1, 2'(i)}) $display("FAIL fill_req_id_%0d: got v%0b id %0d want v1 id %0d", i, cfu_req_valid, cfu_req_id, i); else n_pass++;
    end
    issue_tag = 6'd20; issue_rs1 = 32'h20;
    #1;
    n_total++; if (issue_ready !== 1'b0) $display("FAIL fill_full_ready: got %0b want 0", issue_ready); else n_pass++;
    repeat (2) @(negedge clk);
    n_total++; if ({issue_ready, cfu_req_valid} !== 2'b00) $display("FAIL fill_stalled: got ready %0b req_valid %0b want 0 0", issue_ready, cfu_req_valid); else n_pass++;
    cfu_resp_valid = 1'b1; cfu_resp_id = 2'd0; cfu_resp_data = 32'h100;
    #1;
    n_total++; if (issue_ready !== 1'b0) $display("FAIL fill_no_push_on_pop: got %0b want 0", issue_ready); else n_pass++;
    @(negedge clk);
    n_total++; if ({wb_valid, wb_tag} !== {1'b1, 6'd10}) $display("FAIL fill_wb_first: got v%0b tag %0d want v1 tag 10", wb_valid, wb_tag); else n_pass++;
    n_total++; if (issue_ready !== 1'b1) $display("FAIL fill_ready_after_pop: got %0b want 1", issue_ready); else n_pass++;
    for (int j = 0; j < 4; j++) begin
      cfu_resp_id = 2'((j + 1) % 4); cfu_resp_data = 32'(32'h101 + j);
      @(negedge clk);
      n_total++; if ({wb_valid, wb_err, wb_tag} !== {2'b10, 6'((j < 3) ? 11 + j : 20)}) $display("FAIL fill_drain_%0d: got v%0b err %0b tag %0d want v1 err 0 tag %0d", j, wb_valid, wb_err, wb_tag, (j < 3) ? 11 + j : 20); else n_pass++;
      n_total++; if (wb_data !== 32'(32'h101 + j)) $display("FAIL fill_drain_data_%0d: got %h want %h", j, wb_data, 32'h101 + j); else n_pass++;
      if (j == 0) begin
        n_total++; if ({cfu_req_valid, cfu_req_id} !== 3'b100) $display("FAIL fill_wrap_id: got v%0b id %0d want v1 id 0", cfu_req_valid, cfu_req_id); else n_pass++;
        issue_valid = 1'b0;
      end
    end
    cfu_resp_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_streaming();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      cfu_resp_valid = 1'b0;
      if (c >= 1 && c <= 10) begin
        n_total++; if ({cfu_req_valid, cfu_req_id} !== {1'b1, 2'((c - 1) % 4)}) $display("FAIL stream_req_%0d: got v%0b id %0d want v1 id %0d", c, cfu_req_valid, cfu_req_id, (c - 1) % 4); else n_pass++;
        n_total++; if (cfu_req_data0 !== 32'(c - 1)) $display("FAIL stream_req_data_%0d: got %0d want %0d", c, cfu_req_data0, c - 1); else n_pass++;
        cfu_resp_valid = 1'b1; cfu_resp_id = 2'((c - 1) % 4); cfu_resp_data = 32'(32'h500 + c - 1);
      end
      if (c >= 2) begin
        n_total++; if ({wb_valid, wb_err, wb_tag} !== {2'b10, 6'(30 + c - 2)}) $display("FAIL stream_wb_%0d: got v%0b err %0b tag %0d want v1 err 0 tag %0d", c, wb_valid, wb_err, wb_tag, 30 + c - 2); else n_pass++;
        n_total++; if (wb_data !== 32'(32'h500 + c - 2)) $display("FAIL stream_wb_data_%0d: got %h want %h", c, wb_data, 32'h500 + c - 2); else n_pass++;
      end
      issue_valid = (c < 10); issue_tag = 6'(30 + c); issue_rs1 = 32'(c); issue_funct = 10'(c);
      #1;
      if (c < 10) begin
        n_total++; if (issue_ready !== 1'b1) $display("FAIL stream_ready_%0d: got %0b want 1", c, issue_ready); else n_pass++;
      end
      @(negedge clk);
    end
    cfu_resp_valid = 1'b0;
    n_total++; if ({wb_valid, cfu_req_valid} !== 2'b00) $display("FAIL stream_idle: got wb %0b req %0b want 0 0", wb_valid, cfu_req_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_tag = 6'(40 + i);
      @(negedge clk);
    end
    issue_valid = 1'b0;
    @(negedge clk);
    wb_ready = 1'b0;
    cfu_resp_valid = 1'b1; cfu_resp_id = 2'd0; cfu_resp_data = 32'h600;
    @(negedge clk);
    n_total++; if ({wb_valid, wb_tag, wb_data} !== {1'b1, 6'd40, 32'h600}) $display("FAIL bp_first: got v%0b tag %0d data %h want v1 tag 40 data 600", wb_valid, wb_tag, wb_data); else n_pass++;
    cfu_resp_id = 2'd1; cfu_resp_data = 32'h601;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_total++; if (cfu_resp_ready !== 1'b0) $display("FAIL bp_resp_ready_%0d: got %0b want 0", k, cfu_resp_ready); else n_pass++;
      @(negedge clk);
      n_total++; if ({wb_valid, wb_tag, wb_data} !== {1'b1, 6'd40, 32'h600}) $display("FAIL bp_hold_%0d: got v%0b tag %0d data %h want v1 tag 40 data 600", k, wb_valid, wb_tag, wb_data); else n_pass++;
    end
    wb_ready = 1'b1;
    #1;
    n_total++; if (cfu_resp_ready !== 1'b1) $display("FAIL bp_release_ready: got %0b want 1", cfu_resp_ready); else n_pass++;
    @(negedge clk);
    n_total++; if ({wb_valid, wb_tag, wb_data} !== {1'b1, 6'd41, 32'h601}) $display("FAIL bp_drain1: got v%0b tag %0d data %h want v1 tag 41 data 601", wb_valid, wb_tag, wb_data); else n_pass++;
    cfu_resp_id = 2'd2; cfu_resp_data = 32'h602;
    @(negedge clk);
    cfu_resp_valid = 1'b0;
    n_total++; if ({wb_valid, wb_tag, wb_data} !== {1'b1, 6'd42, 32'h602}) $display("FAIL bp_drain2: got v%0b tag %0d data %h want v1 tag 42 data 602", wb_valid, wb_tag, wb_data); else n_pass++;
    @(negedge clk);
    n_total++; if (wb_valid !== 1'b0) $display("FAIL bp_done: got %0b want 0", wb_valid); else n_pass++;
  endtask

  task automatic test_errors();
    do_reset();
    issue_valid = 1'b1; issue_tag = 6'd7;
    @(negedge clk);
    issue_valid = 1'b0;
    @(negedge clk);
    cfu_resp_valid = 1'b1; cfu_resp_id = 2'd2; cfu_resp_data = 32'h77;
    @(negedge clk);
    cfu_resp_valid = 1'b0;
    n_total++; if ({wb_valid, wb_err, wb_tag} !== {2'b11, 6'd7}) $display("FAIL err_mismatch: got v%0b err %0b tag %0d want v1 err 1 tag 7", wb_valid, wb_err, wb_tag); else n_pass++;
    @(negedge clk);
    cfu_resp_valid = 1'b1; cfu_resp_id = 2'd1; cfu_resp_data = 32'h88;
    @(negedge clk);
    cfu_resp_valid = 1'b0;
    n_total++; if ({err_unexpected, wb_valid} !== 2'b10) $display("FAIL err_unexpected: got err %0b wb %0b want 1 0", err_unexpected, wb_valid); else n_pass++;
    @(negedge clk);
    n_total++; if (err_unexpected !== 1'b1) $display("FAIL err_sticky: got %0b want 1", err_unexpected); else n_pass++;

    issue_valid = 1'b1; issue_tag = 6'd1;
    @(negedge clk);
    issue_tag = 6'd2;
    @(negedge clk);
    issue_valid = 1'b0; cfu_req_ready = 1'b0;
    n_total++; if (cfu_req_valid !== 1'b1) $display("FAIL err_pending_req: got %0b want 1", cfu_req_valid); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_total++; if ({cfu_req_valid, wb_valid, err_unexpected} !== 3'b000) $display("FAIL err_rst_flight: got req %0b wb %0b unexp %0b want 0 0 0", cfu_req_valid, wb_valid, err_unexpected); else n_pass++;
    n_total++; if (issue_ready !== 1'b1) $display("FAIL err_rst_count: got issue_ready %0b want 1", issue_ready); else n_pass++;
    rst = 1'b0; cfu_req_ready = 1'b1;
    cfu_resp_valid = 1'b1; cfu_resp_id = 2'd0; cfu_resp_data = 32'h99;
    @(negedge clk);
    cfu_resp_valid = 1'b0;
    n_total++; if ({err_unexpected, wb_valid} !== 2'b10) $display("FAIL err_late_resp: got err %0b wb %0b want 1 0", err_unexpected, wb_valid); else n_pass++;
  endtask

`ifdef CFU_ISSUE_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    do_reset();
    issue_valid = 1'b1; issue_tag = 6'd9;
    @(negedge clk);
    issue_valid = 1'b0;
    n = 0;
    while (wb_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_total++; if (wb_valid !== 1'b1) $display("FAIL timeout_wb_valid: got %0b want 1 within 40 cycles", wb_valid); else n_pass++;
    n_total++; if ({wb_tag, wb_data, wb_err} !== {6'd9, 32'h0, 1'b1}) $display("FAIL timeout_payload: got tag %0d data %h err %0b want 9 0 1", wb_tag, wb_data, wb_err); else n_pass++;
    n_total++; if (n < 8 || n > 10) $display("FAIL timeout_latency: got %0d cycles want 8..10", n); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_op();
    test_fill();
    test_streaming();
    test_backpressure();
    test_errors();
`ifdef CFU_ISSUE_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cfu_issue_unit.md
Name: cfu_issue_unit

Overview:
- Core-side initiator for the custom-function-unit (CFU) request/response interface; the opposite end from the CFU datapath blocks (e.g. SHA-256 sigma/sum units).
- Accepts CFU instructions from the issue stage and drives a registered CFU request channel.
- Tracks in-flight requests in an in-order tag FIFO and returns CFU responses to writeback with the original instruction tag.
- Sits between the core's CFU issue port and a CFU responder.

Parameters:
- DEPTH, 4, maximum in-flight CFU requests; power of 2, ≥2.
- TAG_W, 6, width of the core writeback tag.
- FUNCT_W, 10, width of the CFU function id.
- TIMEOUT_CYCLES, 256, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- issue_valid  in  1  CFU instruction offered.
- issue_ready  out  1  unit accepts the instruction.
- issue_rs1  in  32  operand 0.
- issue_rs2  in  32  operand 1.
- issue_funct  in  FUNCT_W  function id.
- issue_tag  in  TAG_W  writeback tag.
- cfu_req_valid  out  1  request valid.
- cfu_req_ready  in  1  CFU accepts the request.
- cfu_req_data0  out  32  operand 0.
- cfu_req_data1  out  32  operand 1.
- cfu_req_function_id  out  FUNCT_W  function id.
- cfu_req_id  out  ID_W  request id; ID_W = $clog2(DEPTH).
- cfu_resp_valid  in  1  response valid.
- cfu_resp_ready  out  1  unit accepts the response.
- cfu_resp_data  in  32  result.
- cfu_resp_id  in  ID_W  id echoed by the CFU.
- wb_valid  out  1  result to writeback.
- wb_ready  in  1  writeback accepts.
- wb_data  out  32  result.
- wb_tag  out  TAG_W  tag of the completed instruction.
- wb_err  out  1  id mismatch or timeout on this completion.
- err_unexpected  out  1  sticky: a response arrived with nothing in flight.

Behaviour:
- Reset (single clk with rst=1): cfu_req_valid=0, wb_valid=0, wb_err=0, err_unexpected=0. FIFO pointers=0, count=0. Data outputs are 0. rst mid-operation discards all in-flight state; late responses after reset set err_unexpected.
- Handshake rule: a transfer occurs when valid & ready are both high on a rising clk. A valid, once asserted, holds its payload stable until the transfer.
- issue_ready = (!cfu_req_valid | cfu_req_ready) & (count < DEPTH).
  - count includes the queued request and all outstanding requests.
  - No push when full, even if a pop occurs in the same cycle.
- Issue fire at cycle N:
  - request registers load rs1, rs2 and funct; cfu_req_id = wr_ptr.
  - tag FIFO pushes issue_tag; wr_ptr increments modulo DEPTH.
  - cfu_req_valid=1 from cycle N+1.
- Request fire without a new issue fire: cfu_req_valid clears next cycle. Back-to-back issue gives one request per cycle.
- cfu_resp_ready = (!wb_valid | wb_ready) & (count > 0 | 1). Responses are always drained to avoid deadlock.
- Response fire at cycle M with count>0:
  - FIFO pops the head.
  - wb_data = cfu_resp_data; wb_tag = head tag.
  - wb_err = (cfu_resp_id != rd_ptr).
  - wb_valid=1 at M+1.
- Response fire with count==0: data dropped, err_unexpected set (sticky until rst), no wb.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH, so ids are reused in order. Responses are required in-order; out-of-order returns surface as wb_err.
- wb clears after a wb fire with no new response that cycle.
- Latency: issue → request is 1 cycle; response → wb is 1 cycle.

Optional Feature:
- Macro: CFU_ISSUE_TIMEOUT_EN.
- With the macro:
  - A watchdog counter increments each cycle while count>0 and there is no response fire. It clears on a response fire or when count==0.
  - On reaching TIMEOUT_CYCLES and the wb register being free, the unit pops the head and completes it with wb_data=0, wb_tag=head tag, wb_err=1. The counter then resets.
  - A later response for the abandoned id reports a mismatch or unexpected error.
- Without the macro: no counter, and the unit waits indefinitely.

Decomposition:
- Package cfu_issue_pkg holds:
  - cfu_req_t struct (data0, data1, function_id, id).
  - cfu_resp_t struct (data, id).
  - default width localparams.
  - ID_W derivation.
- Sub-module cfu_tag_fifo: DEPTH×TAG_W, push/pop/count/full/empty, same-cycle push+pop supported.

Test Plan:
- Single op: issue rs1=0x11, rs2=0x22, funct=3, tag=5, CFU responds 2 cycles later with data 0xABCD, id 0 → request seen at cycle 1; wb_data=0xABCD, wb_tag=5, wb_err=0 one cycle after the response.
- Fill: 4 issues with no responses → issue_ready=0 after the 4th. Ids 0,1,2,3 appear on the request channel. A 5th issue is stalled until the first response.
- Wrap/streaming: 10 back-to-back ops with the CFU responding every cycle → ids 0,1,2,3,0,1,... and tags returned in issue order with no bubbles.
- Backpressure: wb_ready=0 for 5 cycles → cfu_resp_ready=0 and wb payload held stable. Release drains the results in order.
- Errors:
  - response with id 2 when head id is 0 → wb_err=1.
  - response with nothing in flight → err_unexpected=1 and no wb_valid.
  - rst mid-flight → all valids=0 and count=0.
- With CFU_ISSUE_TIMEOUT_EN and TIMEOUT_CYCLES=8: no response for the op with tag 9 → wb_valid with tag 9, wb_data=0, wb_err=1 after 8 idle cycles.
